// File: rtl/text_vram_if.sv
// text_vram_if
//   Bundles the game-side write port, the display-side read port and the
//   sweep request/status signals of the character video memory.
//
//   Parameters: RW (row index width), CW (column index width),
//               DW (character code width)
//
//   Signals:
//     wr_en, wr_row, wr_col, wr_data   game write request
//     wr_ack                           one-cycle acknowledge of an accepted write
//     rd_row, rd_col, rd_data          display read address / registered data
//     clr_req, scroll_req              sweep start requests
//     busy, done                       sweep status and completion pulse
//
//   Modports: master (game/display side), slave (memory side).
interface text_vram_if #(
  parameter int RW = 5,
  parameter int CW = 7,
  parameter int DW = 8
);
  logic          wr_en;
  logic [RW-1:0] wr_row;
  logic [CW-1:0] wr_col;
  logic [DW-1:0] wr_data;
  logic          wr_ack;
  logic [RW-1:0] rd_row;
  logic [CW-1:0] rd_col;
  logic [DW-1:0] rd_data;
  logic          clr_req;
  logic          scroll_req;
  logic          busy;
  logic          done;

  modport master (
    output wr_en, wr_row, wr_col, wr_data, rd_row, rd_col, clr_req, scroll_req,
    input  wr_ack, rd_data, busy, done
  );

  modport slave (
    input  wr_en, wr_row, wr_col, wr_data, rd_row, rd_col, clr_req, scroll_req,
    output wr_ack, rd_data, busy, done
  );
endinterface

// File: rtl/text_vram.sv
// text_vram
//   ROWS x COLS character memory for the typing-game display. The game writes
//   single characters by (row, col); the VGA scanner reads one character per
//   cycle with one cycle of latency. A hardware sweep engine clears the whole
//   screen to FILL_CHAR and, optionally, scrolls the screen up by one line.
//
//   Optional feature macro: TEXT_VRAM_SCROLL_EN
//     defined   -> scroll_req honoured (copy pipeline + last-row fill built)
//     undefined -> scroll_req ignored, FSM is IDLE/CLEAR only
//
//   Ports:
//     clk   system clock, all state changes on the rising edge
//     rst   synchronous active-high reset
//     bus   text_vram_if.slave (write port, read port, sweep control/status)
module text_vram #(
  parameter int             COLS      = 70,
  parameter int             ROWS      = 30,
  parameter int             CW        = 7,
  parameter int             RW        = 5,
  parameter int             DW        = 8,
  parameter logic [DW-1:0]  FILL_CHAR = DW'(8'h20)
) (
  input  logic        clk,
  input  logic        rst,
  text_vram_if.slave  bus
);

  localparam int N         = ROWS * COLS;
  localparam int AW        = $clog2(N);
  localparam int COPY_LAST = N - COLS;

`ifdef TEXT_VRAM_SCROLL_EN
  typedef enum logic [1:0] {IDLE, CLEAR, SCROLL_COPY, SCROLL_FILL} state_t;
`else
  typedef enum logic {IDLE, CLEAR} state_t;
`endif

  state_t        r_state;
  logic [AW-1:0] r_cnt;
  logic          r_busy;
  logic          r_done;
  logic          r_wrAck;
  logic [DW-1:0] r_rdData;
  logic [DW-1:0] r_mem [N];

  logic          w_wrInRange;
  logic          w_rdInRange;
  logic [AW-1:0] w_wrAddr;
  logic [AW-1:0] w_rdAddr;
  logic          w_sweepStart;
  logic          w_wrAccept;
  logic          w_sweepWe;
  logic [AW-1:0] w_sweepAddr;
  logic [DW-1:0] w_sweepData;

  // Range checks are done on the raw indices, so an out-of-range column can
  // never alias into the next row's linear address.
  assign w_wrInRange = (32'(bus.wr_row) < 32'(ROWS)) && (32'(bus.wr_col) < 32'(COLS));
  assign w_rdInRange = (32'(bus.rd_row) < 32'(ROWS)) && (32'(bus.rd_col) < 32'(COLS));
  assign w_wrAddr    = AW'(bus.wr_row) * AW'(COLS) + AW'(bus.wr_col);
  assign w_rdAddr    = AW'(bus.rd_row) * AW'(COLS) + AW'(bus.rd_col);

`ifdef TEXT_VRAM_SCROLL_EN
  logic [DW-1:0] r_pipeData;

  assign w_sweepStart = (r_state == IDLE) && (bus.clr_req || bus.scroll_req);

  // First stage of the scroll copy: fetch the character one row below the
  // address that the second stage will write on the following cycle.
  always_ff @(posedge clk) begin
    if (r_state == SCROLL_COPY && r_cnt < AW'(COPY_LAST)) begin
      r_pipeData <= r_mem[r_cnt + AW'(COLS)];
    end
  end
`else
  logic w_unusedScroll;

  assign w_sweepStart   = (r_state == IDLE) && bus.clr_req;
  assign w_unusedScroll = bus.scroll_req;
`endif

  // A sweep starting on the same edge wins over a game write.
  assign w_wrAccept = bus.wr_en && !r_busy && (r_state == IDLE) && !w_sweepStart && w_wrInRange;

  // Sweep write port. In the copy phase the write trails the read by one
  // cycle, so counter value k writes address k-1 and k=0 writes nothing.
  always_comb begin
    w_sweepWe   = 1'b0;
    w_sweepAddr = r_cnt;
    w_sweepData = FILL_CHAR;
    case (r_state)
      CLEAR: w_sweepWe = 1'b1;
`ifdef TEXT_VRAM_SCROLL_EN
      SCROLL_COPY: begin
        if (r_cnt != '0) begin
          w_sweepWe   = 1'b1;
          w_sweepAddr = r_cnt - AW'(1);
          w_sweepData = r_pipeData;
        end
      end
      SCROLL_FILL: w_sweepWe = 1'b1;
`endif
      default: ;
    endcase
  end

  // Memory array is deliberately not reset; a reset edge during a sweep
  // suppresses that edge's write so the screen is left partially swept.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (w_sweepWe) begin
        r_mem[w_sweepAddr] <= w_sweepData;
      end else if (w_wrAccept) begin
        r_mem[w_wrAddr] <= bus.wr_data;
      end
    end
  end

  // Display read port: read-first, out-of-range addresses show the fill char.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rdData <= '0;
    end else begin
      r_rdData <= w_rdInRange ? r_mem[w_rdAddr] : FILL_CHAR;
    end
  end

  // Sweep FSM. The counter walks the linear address space once and holds at
  // its terminal value; it is only rewound when a new sweep starts. Scroll
  // hands over from copy to fill with the counter already at the first
  // address of the last row.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_wrAck <= 1'b0;
    end else begin
      r_done  <= 1'b0;
      r_wrAck <= w_wrAccept;
      case (r_state)
        IDLE: begin
          if (bus.clr_req) begin
            r_state <= CLEAR;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
          end
`ifdef TEXT_VRAM_SCROLL_EN
          else if (bus.scroll_req) begin
            r_state <= SCROLL_COPY;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
          end
`endif
        end
        CLEAR: begin
          if (r_cnt == AW'(N - 1)) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end else begin
            r_cnt <= r_cnt + AW'(1);
          end
        end
`ifdef TEXT_VRAM_SCROLL_EN
        SCROLL_COPY: begin
          if (r_cnt == AW'(COPY_LAST)) begin
            r_state <= SCROLL_FILL;
          end else begin
            r_cnt <= r_cnt + AW'(1);
          end
        end
        SCROLL_FILL: begin
          if (r_cnt == AW'(N - 1)) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end else begin
            r_cnt <= r_cnt + AW'(1);
          end
        end
`endif
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.wr_ack  = r_wrAck;
  assign bus.rd_data = r_rdData;
  assign bus.busy    = r_busy;
  assign bus.done    = r_done;

endmodule

// File: tb/tb_text_vram.sv
// tb_text_vram
//   Self-checking bench for text_vram. A plain array mirrors screen contents
//   and is updated from the behavioural rules of the memory (accepted writes,
//   whole-screen clear, one-line scroll, partial clear on reset abort).
//   Build with +define+TEXT_VRAM_SCROLL_EN to exercise the scroll sweep.
module tb_text_vram;

  localparam int COLS = 70;
  localparam int ROWS = 30;
  localparam int N    = ROWS * COLS;
  localparam logic [7:0] FILL = 8'h20;

  logic clk = 1'b0;
  logic rst = 1'b0;

  always #5 clk = ~clk;

  text_vram_if #(.RW(5), .CW(7), .DW(8)) bus ();

  text_vram #(
    .COLS(COLS), .ROWS(ROWS), .CW(7), .RW(5), .DW(8), .FILL_CHAR(8'h20)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int vectors     = 0;
  int miscompares = 0;
  logic [7:0] model [N];

  // Advance one clock and settle just after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic we, input int row, input int col,
                               input logic [7:0] data, input logic clr, input logic scr);
    bus.wr_en      = we;
    bus.wr_row     = 5'(row);
    bus.wr_col     = 7'(col);
    bus.wr_data    = data;
    bus.clr_req    = clr;
    bus.scroll_req = scr;
  endtask

  task automatic idleInputs();
    applyStimulus(1'b0, 0, 0, 8'h00, 1'b0, 1'b0);
  endtask

  // Observes a running sweep (entered just after the request edge) and counts
  // busy cycles, done pulses and write acks. At iteration pokeAt it drives a
  // write plus both sweep requests for one cycle.
  task automatic waitSweep(input int pokeAt, output int busyCycles,
                           output int doneCount, output int ackCount);
    int guard;
    guard      = 0;
    busyCycles = 0;
    doneCount  = 0;
    ackCount   = 0;
    while (bus.busy === 1'b1 && guard < N + 50) begin
      busyCycles++;
      if (guard == pokeAt) applyStimulus(1'b1, 1, 1, 8'h7e, 1'b1, 1'b1);
      else idleInputs();
      tick();
      guard++;
      if (bus.done === 1'b1) doneCount++;
      if (bus.wr_ack === 1'b1) ackCount++;
    end
    idleInputs();
    repeat (3) begin
      tick();
      if (bus.done === 1'b1) doneCount++;
      if (bus.busy === 1'b1) busyCycles++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idleInputs();
    bus.rd_row = '0;
    bus.rd_col = '0;
    tick();
    tick();
    vectors += 4;
    if (bus.busy !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_busy got %0b want 0", bus.busy); end
    if (bus.done !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_done got %0b want 0", bus.done); end
    if (bus.wr_ack !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_ack got %0b want 0", bus.wr_ack); end
    if (bus.rd_data !== 8'h00) begin miscompares++; $display("[TB] FAIL reset_rd got %02h want 00", bus.rd_data); end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_clear();
    int busyCycles, doneCount, ackCount;
    applyStimulus(1'b0, 0, 0, 8'h00, 1'b1, 1'b0);
    tick();
    idleInputs();
    waitSweep(-1, busyCycles, doneCount, ackCount);
    vectors += 2;
    if (busyCycles != N) begin miscompares++; $display("[TB] FAIL clear_busy_cycles got %0d want %0d", busyCycles, N); end
    if (doneCount != 1) begin miscompares++; $display("[TB] FAIL clear_done_pulses got %0d want 1", doneCount); end
    for (int a = 0; a < N; a++) model[a] = FILL;
    for (int a = 0; a < N; a++) begin
      bus.rd_row = 5'(a / COLS);
      bus.rd_col = 7'(a % COLS);
      tick();
      vectors++;
      if (bus.rd_data !== model[a]) begin
        miscompares++;
        $display("[TB] FAIL clear_read addr %0d got %02h want %02h", a, bus.rd_data, model[a]);
      end
    end
  endtask

  task automatic test_write();
    int rows [3] = '{0, 29, 30};
    int cols [3] = '{0, 69, 0};
    logic [7:0] datas [3] = '{8'h61, 8'h62, 8'h63};
    int r, c;
    logic [7:0] d;
    logic expAck, expRd;
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, rows[i], cols[i], datas[i], 1'b0, 1'b0);
      tick();
      idleInputs();
      expAck = (rows[i] < ROWS) && (cols[i] < COLS);
      if (expAck) model[rows[i] * COLS + cols[i]] = datas[i];
      vectors++;
      if (bus.wr_ack !== expAck) begin miscompares++; $display("[TB] FAIL write_ack #%0d got %0b want %0b", i, bus.wr_ack, expAck); end
      bus.rd_row = 5'(rows[i]);
      bus.rd_col = 7'(cols[i]);
      tick();
      expRd = 1'b0;
      vectors += 2;
      if (bus.wr_ack !== expRd) begin miscompares++; $display("[TB] FAIL write_ack_width #%0d got %0b want 0", i, bus.wr_ack); end
      d = expAck ? datas[i] : FILL;
      if (bus.rd_data !== d) begin miscompares++; $display("[TB] FAIL write_readback #%0d got %02h want %02h", i, bus.rd_data, d); end
    end
    for (int i = 0; i < 40; i++) begin
      r = $urandom_range(0, 31);
      c = $urandom_range(0, 79);
      d = 8'($urandom_range(0, 255));
      applyStimulus(1'b1, r, c, d, 1'b0, 1'b0);
      tick();
      expAck = (r < ROWS) && (c < COLS);
      if (expAck) model[r * COLS + c] = d;
      vectors++;
      if (bus.wr_ack !== expAck) begin miscompares++; $display("[TB] FAIL rand_write_ack (%0d,%0d) got %0b want %0b", r, c, bus.wr_ack, expAck); end
    end
    idleInputs();
    for (int i = 0; i < 60; i++) begin
      r = (i < 10) ? 29 : $urandom_range(0, 31);
      c = $urandom_range(0, 79);
      bus.rd_row = 5'(r);
      bus.rd_col = 7'(c);
      tick();
      d = ((r < ROWS) && (c < COLS)) ? model[r * COLS + c] : FILL;
      vectors++;
      if (bus.rd_data !== d) begin miscompares++; $display("[TB] FAIL rand_read (%0d,%0d) got %02h want %02h", r, c, bus.rd_data, d); end
    end
  endtask

  task automatic test_read_first();
    logic [7:0] oldVal;
    applyStimulus(1'b1, 3, 5, 8'h55, 1'b0, 1'b0);
    tick();
    model[3 * COLS + 5] = 8'h55;
    oldVal = model[3 * COLS + 5];
    applyStimulus(1'b1, 3, 5, 8'h41, 1'b0, 1'b0);
    bus.rd_row = 5'd3;
    bus.rd_col = 7'd5;
    tick();
    idleInputs();
    vectors += 2;
    if (bus.rd_data !== oldVal) begin miscompares++; $display("[TB] FAIL read_first_old got %02h want %02h", bus.rd_data, oldVal); end
    if (bus.wr_ack !== 1'b1) begin miscompares++; $display("[TB] FAIL read_first_ack got %0b want 1", bus.wr_ack); end
    model[3 * COLS + 5] = 8'h41;
    tick();
    vectors++;
    if (bus.rd_data !== 8'h41) begin miscompares++; $display("[TB] FAIL read_first_new got %02h want 41", bus.rd_data); end
  endtask

  task automatic test_scroll();
    int busyCycles, doneCount, ackCount;
    int a;
    for (int r = 0; r < ROWS; r++) begin
      for (int c = 0; c < COLS; c++) begin
        applyStimulus(1'b1, r, c, 8'(8'h30 + r), 1'b0, 1'b0);
        tick();
        model[r * COLS + c] = 8'(8'h30 + r);
        vectors++;
        if (bus.wr_ack !== 1'b1) begin miscompares++; $display("[TB] FAIL fill_ack (%0d,%0d) got %0b want 1", r, c, bus.wr_ack); end
      end
    end
    applyStimulus(1'b0, 0, 0, 8'h00, 1'b0, 1'b1);
    tick();
    idleInputs();
`ifdef TEXT_VRAM_SCROLL_EN
    waitSweep(-1, busyCycles, doneCount, ackCount);
    vectors += 2;
    if (busyCycles != N + 1) begin miscompares++; $display("[TB] FAIL scroll_busy_cycles got %0d want %0d", busyCycles, N + 1); end
    if (doneCount != 1) begin miscompares++; $display("[TB] FAIL scroll_done_pulses got %0d want 1", doneCount); end
    // Screen moves up one line; the bottom line becomes blank.
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        model[r * COLS + c] = (r < ROWS - 1) ? model[(r + 1) * COLS + c] : FILL;
    for (int i = 0; i < N; i++) begin
      bus.rd_row = 5'(i / COLS);
      bus.rd_col = 7'(i % COLS);
      tick();
      vectors++;
      if (bus.rd_data !== model[i]) begin
        miscompares++;
        $display("[TB] FAIL scroll_read addr %0d got %02h want %02h", i, bus.rd_data, model[i]);
      end
    end
`else
    busyCycles = 0;
    doneCount  = 0;
    ackCount   = 0;
    repeat (4) begin
      if (bus.busy === 1'b1) busyCycles++;
      if (bus.done === 1'b1) doneCount++;
      tick();
    end
    vectors += 2;
    if (busyCycles != 0) begin miscompares++; $display("[TB] FAIL scroll_ignored_busy got %0d want 0", busyCycles); end
    if (doneCount != 0) begin miscompares++; $display("[TB] FAIL scroll_ignored_done got %0d want 0", doneCount); end
    for (int i = 0; i < 40; i++) begin
      a = $urandom_range(0, N - 1);
      bus.rd_row = 5'(a / COLS);
      bus.rd_col = 7'(a % COLS);
      tick();
      vectors++;
      if (bus.rd_data !== model[a]) begin miscompares++; $display("[TB] FAIL scroll_ignored_read addr %0d got %02h want %02h", a, bus.rd_data, model[a]); end
    end
`endif
  endtask

  task automatic test_priority();
    int busyCycles, doneCount, ackCount;
    int a;
    applyStimulus(1'b1, 2, 2, 8'h7a, 1'b1, 1'b1);
    tick();
    idleInputs();
    vectors++;
    if (bus.wr_ack !== 1'b0) begin miscompares++; $display("[TB] FAIL prio_write_dropped got %0b want 0", bus.wr_ack); end
    waitSweep(500, busyCycles, doneCount, ackCount);
    vectors += 3;
    if (busyCycles != N) begin miscompares++; $display("[TB] FAIL prio_busy_cycles got %0d want %0d", busyCycles, N); end
    if (doneCount != 1) begin miscompares++; $display("[TB] FAIL prio_done_pulses got %0d want 1", doneCount); end
    if (ackCount != 0) begin miscompares++; $display("[TB] FAIL prio_busy_write_ack got %0d want 0", ackCount); end
    for (int i = 0; i < N; i++) model[i] = FILL;
    for (int i = 0; i < 30; i++) begin
      a = (i == 0) ? 2 * COLS + 2 : $urandom_range(0, N - 1);
      bus.rd_row = 5'(a / COLS);
      bus.rd_col = 7'(a % COLS);
      tick();
      vectors++;
      if (bus.rd_data !== model[a]) begin miscompares++; $display("[TB] FAIL prio_read addr %0d got %02h want %02h", a, bus.rd_data, model[a]); end
    end
  endtask

  task automatic test_back_to_back();
    int busyCycles, doneCount, ackCount;
    int guard;
    logic sawDone;
    applyStimulus(1'b0, 0, 0, 8'h00, 1'b1, 1'b0);
    tick();
    idleInputs();
    sawDone = 1'b0;
    guard   = 0;
    while (!sawDone && guard < N + 50) begin
      tick();
      guard++;
      if (bus.done === 1'b1) sawDone = 1'b1;
    end
    vectors++;
    if (sawDone !== 1'b1) begin miscompares++; $display("[TB] FAIL b2b_first_done got %0b want 1", sawDone); end
    applyStimulus(1'b0, 0, 0, 8'h00, 1'b1, 1'b0);
    tick();
    idleInputs();
    vectors++;
    if (bus.busy !== 1'b1) begin miscompares++; $display("[TB] FAIL b2b_restart_busy got %0b want 1", bus.busy); end
    waitSweep(-1, busyCycles, doneCount, ackCount);
    vectors += 2;
    if (busyCycles != N) begin miscompares++; $display("[TB] FAIL b2b_busy_cycles got %0d want %0d", busyCycles, N); end
    if (doneCount != 1) begin miscompares++; $display("[TB] FAIL b2b_done_pulses got %0d want 1", doneCount); end
  endtask

  task automatic test_reset_abort();
    int doneCount;
    logic [7:0] d;
    for (int a = 0; a < N; a++) begin
      d = 8'($urandom_range(0, 255));
      applyStimulus(1'b1, a / COLS, a % COLS, d, 1'b0, 1'b0);
      tick();
      model[a] = d;
    end
    applyStimulus(1'b0, 0, 0, 8'h00, 1'b1, 1'b0);
    tick();
    idleInputs();
    repeat (1000) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    vectors += 2;
    if (bus.busy !== 1'b0) begin miscompares++; $display("[TB] FAIL abort_busy got %0b want 0", bus.busy); end
    if (bus.done !== 1'b0) begin miscompares++; $display("[TB] FAIL abort_done got %0b want 0", bus.done); end
    doneCount = 0;
    repeat (5) begin
      tick();
      if (bus.done === 1'b1 || bus.busy === 1'b1) doneCount++;
    end
    vectors++;
    if (doneCount != 0) begin miscompares++; $display("[TB] FAIL abort_quiet got %0d want 0", doneCount); end
    for (int a = 0; a < 1000; a++) model[a] = FILL;
    for (int a = 0; a < N; a++) begin
      bus.rd_row = 5'(a / COLS);
      bus.rd_col = 7'(a % COLS);
      tick();
      vectors++;
      if (bus.rd_data !== model[a]) begin
        miscompares++;
        $display("[TB] FAIL abort_read addr %0d got %02h want %02h", a, bus.rd_data, model[a]);
      end
    end
  endtask

  initial begin
    #3000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    idleInputs();
    bus.rd_row = '0;
    bus.rd_col = '0;
    test_reset();
    test_clear();
    test_write();
    test_read_first();
    test_scroll();
    test_priority();
    test_back_to_back();
    test_reset_abort();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/text_vram.md
# text_vram

Parametrised character video memory for the typing-game display path. It stores ROWS×COLS character codes and exposes two ports:
- a game-side write port, addressed by row and column;
- a display-side synchronous read port for the VGA character scanner.

An internal sweep engine clears the screen to a fill character and, when compiled in, scrolls the screen up one line. Both run in hardware, with no per-character work by the game logic.

## Interface
- COLS, 70, characters per row
- ROWS, 30, rows on screen
- CW, 7, column index width (≥ clog2(COLS))
- RW, 5, row index width (≥ clog2(ROWS))
- DW, 8, character code width
- FILL_CHAR, 8'h20, value written by clear and by scroll's last-row fill

Ports:
- clk  in  1  system clock; all state changes on rising edge
- rst  in  1  synchronous, active-high reset
- wr_en  in  1  write request
- wr_row  in  RW  write row
- wr_col  in  CW  write column
- wr_data  in  DW  character to write
- wr_ack  out  1  registered; 1 for one cycle after an accepted write
- rd_row  in  RW  display read row
- rd_col  in  CW  display read column
- rd_data  out  DW  registered read data
- clr_req  in  1  start clear sweep (level sampled per cycle)
- scroll_req  in  1  start scroll sweep (only with TEXT_VRAM_SCROLL_EN)
- busy  out  1  sweep in progress
- done  out  1  one-cycle pulse when a sweep completes

## Operation
- Linear address = row*COLS + col, computed at DW-independent width clog2(ROWS*COLS).
- Write is accepted when wr_en=1, busy=0, no sweep starts that cycle, row<ROWS and col<COLS.
  - Memory updates at that edge.
  - wr_ack=1 on the following cycle.
  - Out-of-range or blocked writes are dropped with wr_ack=0.
- Read: rd_data at edge t+1 reflects memory at the address sampled at edge t. Read-first: a same-cycle write or sweep to that address returns the old value. An out-of-range address returns FILL_CHAR.
- FSM states: IDLE, CLEAR, SCROLL_COPY, SCROLL_FILL.
  - IDLE→CLEAR when clr_req=1.
  - IDLE→SCROLL_COPY when scroll_req=1 and clr_req=0 (clear has priority).
  - CLEAR: writes FILL_CHAR to address k, k=0..N-1 (N=ROWS*COLS), one per cycle, then →IDLE.
  - SCROLL_COPY: reads address k+COLS and writes the result to address k one cycle later (2-stage pipeline), k=0..N-COLS-1, then →SCROLL_FILL.
  - SCROLL_FILL: writes FILL_CHAR to the last row's COLS addresses, then →IDLE.
- Requests arriving while busy=1 are ignored (not queued).
- Display reads continue during sweeps.
- Reset values:
  - FSM IDLE, busy=0, done=0, wr_ack=0, rd_data=0.
  - Sweep counter 0.
  - Memory contents not reset.

## Timing
- Write latency: 1 cycle to memory; wr_ack 1 cycle after the accepting edge.
- Read latency: 1 cycle.
- Sweep request sampled at edge t:
  - busy=1 from t+1.
  - Clear occupies N cycles; scroll occupies N+1 cycles (includes the pipeline flush).
  - On the edge ending the last sweep cycle: busy→0 and done=1 for exactly one cycle.
- A new request is accepted on the first cycle where busy=0, including the cycle done=1.
- Same-edge write and sweep request: the sweep starts and the write is dropped.
- rst during a sweep: abort at that edge. busy=0 and done=0 next cycle; memory is left partially swept; no completion pulse is generated.
- Counter wrap: the sweep counter stops at its terminal value and never wraps into a second pass.

## Configuration
- TEXT_VRAM_SCROLL_EN defined:
  - scroll_req is honoured.
  - SCROLL_COPY and SCROLL_FILL are built, along with the internal read pipeline.
- Not defined:
  - scroll_req is ignored.
  - The FSM has only IDLE and CLEAR.
  - No scroll logic is synthesised.
  - Port list is unchanged.

## Test plan
- Reset, then clr_req pulse → busy high for 2100 cycles, done pulse once, every address reads 8'h20.
- Write 8'h61 at (0,0) and 8'h62 at (29,69) → wr_ack 1 cycle later each; reads return 8'h61/8'h62 after 1 cycle. Write to (30,0) → wr_ack=0, memory unchanged.
- Read (3,5) on the same edge as a write of 8'h41 there → rd_data shows the old value; the next read shows 8'h41.
- With TEXT_VRAM_SCROLL_EN, fill row r with 8'h30+r, then scroll_req:
  - busy for 2101 cycles.
  - Row r afterwards holds 8'h31+r for r<29.
  - Row 29 holds 8'h20.
- Assert wr_en, clr_req and scroll_req together in IDLE → clear runs; write dropped; scroll not started. Repeat clr_req while busy → no restart, single done.
- rst asserted at sweep cycle 1000 → busy=0 next cycle, no done pulse; addresses 0..999 hold 8'h20, and the rest keep their prior values.
